lsu_controller: RTL and testbench
=================================

Name: lsu_controller

Overview:
Load/store sequencer between the execute stage and the data-memory bus. Accepts one decoded memory operation at a time: mem_op, mem_sel, the ALU-computed effective address and the rs2 store data. Checks alignment, drives a valid/ready bus transaction with byte strobes, then returns a sign- or zero-extended load result or an error flag. Drives busy so the pipeline stalls while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 16, bus_valid cycles without bus_ready before the access aborts with an error; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  execute stage presents an operation
req_ready  output  1  controller can accept; high only in IDLE
mem_op  input  2  operation code; encodings from inc/memory_opcode.v (MEM_OP_NOP, MEM_OP_LOAD, MEM_OP_STORE)
mem_sel  input  3  access size; encodings from inc/memory_select.v (MEM_SEL_BYTE_SIGNED, MEM_SEL_BYTE_UNSIGNED, MEM_SEL_HALF_SIGNED, MEM_SEL_HALF_UNSIGNED, MEM_SEL_WORD, MEM_SEL_NOP)
addr  input  32  effective byte address
store_data  input  32  rs2 value
bus_valid  output  1  bus request
bus_ready  input  1  bus accepts or completes the request
bus_we  output  1  1 = write
bus_addr  output  32  word address, {addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_wstrb  output  4  byte enables; 4'b0000 on reads
bus_rdata  input  32  read word, valid in the bus_valid&bus_ready cycle
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores, NOP and errors
resp_err  output  1  misaligned access, invalid sel, or timeout; qualified by resp_valid
busy  output  1  state != IDLE

Behaviour:
- Reset: state IDLE. req_ready=1. bus_valid, bus_we, resp_valid and resp_err are 0. bus_addr, bus_wdata, bus_wstrb, resp_rdata and the timeout counter are 0.
- Reset mid-operation has the same effect. bus_valid drops at that edge and no response is issued.
- States: IDLE, BUS, RESP.
- IDLE: on req_valid, latch op, sel, addr and store_data, then choose the next state:
  - MEM_OP_NOP goes to RESP with err=0.
  - LOAD/STORE with MEM_SEL_NOP goes to RESP with err=1.
  - Misaligned access goes to RESP with err=1. Misaligned means a half with addr[0]=1, or a word with addr[1:0]!=0. No bus cycle is issued.
  - Otherwise go to BUS.
- BUS:
  - bus_valid=1. bus_addr, bus_we, bus_wdata and bus_wstrb are registered and stay stable until the handshake.
  - On bus_valid&bus_ready, capture the lane from bus_rdata and go to RESP with err=0.
  - The counter increments each BUS cycle without bus_ready. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, drop bus_valid and go to RESP with err=1.
  - A handshake in the same cycle the counter reaches TIMEOUT_CYCLES wins: the access succeeds.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. A new request is accepted one cycle after resp_valid, since that is when req_ready is high again.
- Strobes, where o=addr[1:0]:
  - Byte: 4'b0001<<o.
  - Half: 4'b0011<<o.
  - Word: 4'b1111.
  - BYTE_SIGNED and BYTE_UNSIGNED behave identically for stores; likewise for the two half selects.
- wdata lane replication:
  - Byte: {4{store_data[7:0]}}.
  - Half: {2{store_data[15:0]}}.
  - Word: store_data.
- Load extract:
  - Byte takes bus_rdata[8o+7:8o]; half takes bus_rdata[8o+15:8o].
  - *_SIGNED selects replicate the MSB into the upper bits; *_UNSIGNED selects zero-fill.
- Latency with bus_ready tied high: accept at cycle T, bus_valid at T+1, resp_valid at T+2.
- Latency for error or NOP: resp_valid at T+1.

Test Plan:
- Aligned load, bus_ready tied 1: LOAD, HALF_SIGNED, addr=0x1002, bus_rdata=0x8001_1234. bus_addr=0x1000, wstrb=0000, we=0. resp_valid at T+2 with resp_rdata=0xFFFF8001, err=0.
- Byte store, wait states: STORE, BYTE_SIGNED, addr=0x2003, store_data=0xAABBCCDD, bus_ready asserted after 3 cycles.
  - wstrb=1000, wdata=0xDDDDDDDD, both held stable while waiting.
  - resp_valid one cycle after the handshake, resp_rdata=0.
- Unsigned byte load: LOAD, BYTE_UNSIGNED, addr=0x01, bus_rdata=0x0000F000. resp_rdata=0x000000F0.
- Misaligned word: LOAD, WORD, addr=0x06. bus_valid is never asserted. resp_valid at T+1 with err=1.
- Timeout: TIMEOUT_CYCLES=4, bus_ready held 0. bus_valid drops after the 4th cycle, resp_err=1, and the next request is accepted normally.
- rst_n low during BUS: bus_valid=0 and req_ready=1 after that edge. No resp_valid appears afterward.

Source files
------------

// File: rtl/lsu_controller.sv
// Load/store sequencer between execute and the data-memory bus: checks alignment, runs one
// valid/ready transaction with byte strobes and returns an extended load result or an error.
module lsu_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  mem_op,
    input  logic [2:0]  mem_sel,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [1:0] MEM_OP_NOP   = 2'b00;
    localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
    localparam logic [1:0] MEM_OP_STORE = 2'b10;

    localparam logic [2:0] MEM_SEL_BYTE_SIGNED   = 3'b000;
    localparam logic [2:0] MEM_SEL_HALF_SIGNED   = 3'b001;
    localparam logic [2:0] MEM_SEL_WORD          = 3'b010;
    localparam logic [2:0] MEM_SEL_BYTE_UNSIGNED = 3'b100;
    localparam logic [2:0] MEM_SEL_HALF_UNSIGNED = 3'b101;
    localparam logic [2:0] MEM_SEL_NOP           = 3'b111;

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e      state_q;
    logic [2:0]  sel_q;
    logic [1:0]  off_q;
    logic [31:0] tmo_q;

    logic        is_byte, is_half, is_word, is_mem, misaligned, timeout_hit;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c, lane_c, load_c, tmo_next;

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

    assign is_mem  = (mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE);
    assign is_byte = (mem_sel == MEM_SEL_BYTE_SIGNED) || (mem_sel == MEM_SEL_BYTE_UNSIGNED);
    assign is_half = (mem_sel == MEM_SEL_HALF_SIGNED) || (mem_sel == MEM_SEL_HALF_UNSIGNED);
    assign is_word = (mem_sel == MEM_SEL_WORD);
    assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

    assign tmo_next    = tmo_q + 32'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_next == TIMEOUT_CYCLES);

    always_comb begin
        strb_c  = 4'b1111;
        wdata_c = store_data;
        if (is_byte) begin
            strb_c  = 4'b0001 << addr[1:0];
            wdata_c = {4{store_data[7:0]}};
        end else if (is_half) begin
            strb_c  = 4'b0011 << addr[1:0];
            wdata_c = {2{store_data[15:0]}};
        end
    end

    // Load lane is selected from the offset latched at accept time.
    assign lane_c = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_c = 32'd0;
        case (sel_q)
            MEM_SEL_BYTE_SIGNED:   load_c = {{24{lane_c[7]}}, lane_c[7:0]};
            MEM_SEL_BYTE_UNSIGNED: load_c = {24'd0, lane_c[7:0]};
            MEM_SEL_HALF_SIGNED:   load_c = {{16{lane_c[15]}}, lane_c[15:0]};
            MEM_SEL_HALF_UNSIGNED: load_c = {16'd0, lane_c[15:0]};
            MEM_SEL_WORD:          load_c = bus_rdata;
            default:               load_c = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sel_q      <= MEM_SEL_NOP;
            off_q      <= 2'b00;
            tmo_q      <= 32'd0;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_wstrb  <= 4'b0000;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        sel_q <= mem_sel;
                        off_q <= addr[1:0];
                        tmo_q <= 32'd0;
                        if (!is_mem) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                        end else if (!(is_byte || is_half || is_word) || misaligned) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state_q   <= StBus;
                            bus_valid <= 1'b1;
                            bus_we    <= (mem_op == MEM_OP_STORE);
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= (mem_op == MEM_OP_STORE) ? wdata_c : 32'd0;
                            bus_wstrb <= (mem_op == MEM_OP_STORE) ? strb_c : 4'b0000;
                        end
                    end
                end
                StBus: begin
                    // A handshake takes priority over a timeout landing in the same cycle.
                    if (bus_ready) begin
                        state_q    <= StResp;
                        bus_valid  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= bus_we ? 32'd0 : load_c;
                    end else begin
                        tmo_q <= tmo_next;
                        if (timeout_hit) begin
                            state_q    <= StResp;
                            bus_valid  <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    state_q    <= StIdle;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: loads, stores, wait states, misalignment, timeout and reset.
module tb_lsu_controller;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [2:0] SEL_BS   = 3'b000;
    localparam logic [2:0] SEL_HS   = 3'b001;
    localparam logic [2:0] SEL_W    = 3'b010;
    localparam logic [2:0] SEL_BU   = 3'b100;
    localparam logic [2:0] SEL_HU   = 3'b101;
    localparam logic [2:0] SEL_NOP  = 3'b111;

    logic        clk, rst_n, req_valid, req_ready, bus_valid, bus_ready, bus_we;
    logic        resp_valid, resp_err, busy;
    logic [1:0]  mem_op;
    logic [2:0]  mem_sel;
    logic [31:0] addr, store_data, bus_addr, bus_wdata, bus_rdata, resp_rdata;
    logic [3:0]  bus_wstrb;

    int tests = 0;
    int fails = 0;

    lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_op     (mem_op),
        .mem_sel    (mem_sel),
        .addr       (addr),
        .store_data (store_data),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_rdata  (bus_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single accept edge; returns in the cycle after acceptance.
    task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid  = 1'b1;
        mem_op     = op;
        mem_sel    = sel;
        addr       = a;
        store_data = d;
        step();
        req_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_op = OP_NOP; mem_sel = SEL_NOP;
        addr = 32'd0; store_data = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);

        // Aligned signed half load, bus_ready tied high
        bus_ready = 1'b1; bus_rdata = 32'h8001_1234;
        issue(OP_LOAD, SEL_HS, 32'h0000_1002, 32'd0);
        chk("lh_bus_valid", 32'(bus_valid), 32'd1);
        chk("lh_bus_addr", bus_addr, 32'h0000_1000);
        chk("lh_wstrb", 32'(bus_wstrb), 32'd0);
        chk("lh_we", 32'(bus_we), 32'd0);
        chk("lh_busy", 32'(busy), 32'd1);
        chk("lh_req_ready", 32'(req_ready), 32'd0);
        chk("lh_no_early_resp", 32'(resp_valid), 32'd0);
        step();
        chk("lh_resp_valid", 32'(resp_valid), 32'd1);
        chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
        chk("lh_err", 32'(resp_err), 32'd0);
        chk("lh_bus_dropped", 32'(bus_valid), 32'd0);
        step();
        chk("lh_resp_pulse", 32'(resp_valid), 32'd0);
        chk("lh_ready_again", 32'(req_ready), 32'd1);

        // Byte store with 3 wait cycles; ready arrives as the counter would hit 4
        bus_ready = 1'b0;
        issue(OP_STORE, SEL_BS, 32'h0000_2003, 32'hAABB_CCDD);
        for (int i = 0; i < 3; i++) begin
            chk("sb_wait_valid", 32'(bus_valid), 32'd1);
            chk("sb_wait_strb", 32'(bus_wstrb), 32'h8);
            chk("sb_wait_wdata", bus_wdata, 32'hDDDD_DDDD);
            chk("sb_wait_we", 32'(bus_we), 32'd1);
            chk("sb_wait_addr", bus_addr, 32'h0000_2000);
            chk("sb_wait_no_resp", 32'(resp_valid), 32'd0);
            step();
        end
        bus_ready = 1'b1;
        chk("sb_hs_valid", 32'(bus_valid), 32'd1);
        step();
        bus_ready = 1'b0;
        chk("sb_resp_valid", 32'(resp_valid), 32'd1);
        chk("sb_resp_err", 32'(resp_err), 32'd0);
        chk("sb_resp_rdata", resp_rdata, 32'd0);
        step();

        // Half store strobes and replication at offset 2
        bus_ready = 1'b1;
        issue(OP_STORE, SEL_HU, 32'h0000_3002, 32'h1234_ABCD);
        chk("sh_strb", 32'(bus_wstrb), 32'hC);
        chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        step();
        step();

        // Unsigned byte load at offset 1
        bus_rdata = 32'h0000_F000;
        issue(OP_LOAD, SEL_BU, 32'h0000_0001, 32'd0);
        step();
        chk("lbu_resp_valid", 32'(resp_valid), 32'd1);
        chk("lbu_rdata", resp_rdata, 32'h0000_00F0);
        step();

        // Misaligned word: error at T+1 with no bus cycle
        issue(OP_LOAD, SEL_W, 32'h0000_0006, 32'd0);
        chk("mis_bus_valid", 32'(bus_valid), 32'd0);
        chk("mis_resp_valid", 32'(resp_valid), 32'd1);
        chk("mis_err", 32'(resp_err), 32'd1);
        chk("mis_rdata", resp_rdata, 32'd0);
        step();

        // NOP completes cleanly; invalid sel errors
        issue(OP_NOP, SEL_W, 32'h0000_0000, 32'd0);
        chk("nop_resp_valid", 32'(resp_valid), 32'd1);
        chk("nop_err", 32'(resp_err), 32'd0);
        step();
        issue(OP_LOAD, SEL_NOP, 32'h0000_0000, 32'd0);
        chk("selnop_resp_valid", 32'(resp_valid), 32'd1);
        chk("selnop_err", 32'(resp_err), 32'd1);
        step();

        // Timeout after 4 cycles of bus_valid without ready
        bus_ready = 1'b0;
        issue(OP_LOAD, SEL_W, 32'h0000_0010, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("to_valid_held", 32'(bus_valid), 32'd1);
            step();
        end
        chk("to_bus_dropped", 32'(bus_valid), 32'd0);
        chk("to_resp_valid", 32'(resp_valid), 32'd1);
        chk("to_err", 32'(resp_err), 32'd1);
        step();
        chk("to_ready_again", 32'(req_ready), 32'd1);
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        issue(OP_LOAD, SEL_W, 32'h0000_0020, 32'd0);
        step();
        chk("post_to_resp", 32'(resp_valid), 32'd1);
        chk("post_to_rdata", resp_rdata, 32'h1234_5678);
        chk("post_to_err", 32'(resp_err), 32'd0);
        step();

        // Reset during BUS aborts without a response
        bus_ready = 1'b0;
        issue(OP_LOAD, SEL_W, 32'h0000_0040, 32'd0);
        chk("rb_in_bus", 32'(bus_valid), 32'd1);
        rst_n = 1'b0;
        step();
        chk("rb_bus_valid", 32'(bus_valid), 32'd0);
        chk("rb_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rb_no_resp", 32'(resp_valid), 32'd0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
